// File: rtl/unidade_load_store.sv
// unidade_load_store
// Load/store controller between the memory-access stage of the processor and
// a data memory with a registered read port. One request is handled at a time.
// Word stores write directly. Loads read the memory and return the word or an
// extended byte. Byte stores do a read-modify-write so that the other lane of
// the stored word is preserved.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-low reset
//   req              request strobe, only looked at while idle
//   escrita          1 = store, 0 = load
//   byte_acc         1 = byte access, 0 = word access
//   sel_byte         byte lane (0 = [7:0], 1 = [15:8])
//   com_sinal        byte load: 1 = sign-extend, 0 = zero-extend
//   endereco_in      word address of the request
//   dado_in          store data (a byte store uses the low 8 bits)
//   dado_out         registered load result
//   ocupado          high while an operation is in progress
//   pronto           one-cycle completion pulse
//   mem_hab_escrita  memory write enable
//   mem_endereco     memory address (held after completion)
//   mem_entrada      memory write data
//   mem_saida        memory read data, valid one cycle after the address
module unidade_load_store #(
   parameter int bits_palavra  = 16,
   parameter int end_registros = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req,
   input  logic                     escrita,
   input  logic                     byte_acc,
   input  logic                     sel_byte,
   input  logic                     com_sinal,
   input  logic [end_registros-1:0] endereco_in,
   input  logic [bits_palavra-1:0]  dado_in,
   output logic [bits_palavra-1:0]  dado_out,
   output logic                     ocupado,
   output logic                     pronto,
   output logic                     mem_hab_escrita,
   output logic [end_registros-1:0] mem_endereco,
   output logic [bits_palavra-1:0]  mem_entrada,
   input  logic [bits_palavra-1:0]  mem_saida
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      LE      = 2'd1,
      CAPTURA = 2'd2,
      ESCREVE = 2'd3
   } estado_t;

   estado_t estado;
   estado_t proximo;

   logic                     aceita;
   logic                     conclui;
   logic                     escrita_r;
   logic                     byte_r;
   logic                     sel_r;
   logic                     sinal_r;
   logic [7:0]               byte_dado_r;
   logic [end_registros-1:0] endereco_r;
   logic [bits_palavra-1:0]  entrada_r;
   logic [bits_palavra-1:0]  dado_out_r;
   logic                     pronto_r;
   logic [7:0]               faixa;
   logic [bits_palavra-1:0]  carga;
   logic [bits_palavra-1:0]  mesclado;

   // State register. Reset returns to idle at once, which also drops the
   // write enable, so an aborted byte store never reaches the memory.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= proximo;
      end
   end

   // Next-state logic. 'aceita' marks the edge that latches a new request;
   // 'conclui' marks the last busy cycle, so pronto rises in the first idle
   // cycle that follows.
   always_comb begin
      proximo = estado;
      aceita  = 1'b0;
      conclui = 1'b0;
      case (estado)
         OCIOSO: begin
            if (req) begin
               aceita  = 1'b1;
               proximo = (escrita && !byte_acc) ? ESCREVE : LE;
            end
         end
         LE: begin
            proximo = CAPTURA;
         end
         CAPTURA: begin
            if (escrita_r) begin
               proximo = ESCREVE;
            end else begin
               proximo = OCIOSO;
               conclui = 1'b1;
            end
         end
         ESCREVE: begin
            proximo = OCIOSO;
            conclui = 1'b1;
         end
         default: begin
            proximo = OCIOSO;
         end
      endcase
   end

   // Data returned by the memory in CAPTURA: the load result (word, or the
   // selected lane extended) and the merged word for a byte store, where the
   // lane not being written keeps the value just read.
   always_comb begin
      faixa    = sel_r ? mem_saida[15:8] : mem_saida[7:0];
      carga    = mem_saida;
      mesclado = mem_saida;
      if (byte_r) begin
         if (sinal_r) begin
            carga = {{(bits_palavra-8){faixa[7]}}, faixa};
         end else begin
            carga = {{(bits_palavra-8){1'b0}}, faixa};
         end
      end
      if (sel_r) begin
         mesclado = {byte_dado_r, mem_saida[7:0]};
      end else begin
         mesclado = {mem_saida[15:8], byte_dado_r};
      end
   end

   // Request latches and result registers. The write-data register takes the
   // store word on accept (used directly by a word store) and is overwritten
   // with the merged word in CAPTURA for a byte store. dado_out only changes
   // when a load completes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         escrita_r   <= 1'b0;
         byte_r      <= 1'b0;
         sel_r       <= 1'b0;
         sinal_r     <= 1'b0;
         byte_dado_r <= '0;
         endereco_r  <= '0;
         entrada_r   <= '0;
         dado_out_r  <= '0;
         pronto_r    <= 1'b0;
      end else begin
         pronto_r <= conclui;
         if (aceita) begin
            escrita_r   <= escrita;
            byte_r      <= byte_acc;
            sel_r       <= sel_byte;
            sinal_r     <= com_sinal;
            byte_dado_r <= dado_in[7:0];
            endereco_r  <= endereco_in;
            entrada_r   <= dado_in;
         end
         if (estado == CAPTURA) begin
            if (escrita_r) begin
               entrada_r <= mesclado;
            end else begin
               dado_out_r <= carga;
            end
         end
      end
   end

   // Outputs are taken from registers or from the state register only.
   assign dado_out        = dado_out_r;
   assign pronto          = pronto_r;
   assign ocupado         = (estado != OCIOSO);
   assign mem_hab_escrita = (estado == ESCREVE);
   assign mem_endereco    = endereco_r;
   assign mem_entrada     = entrada_r;

endmodule

// File: tb/tb_unidade_load_store.sv
// tb_unidade_load_store
// Self-checking bench for unidade_load_store. A behavioural data memory with
// a registered read port is attached to the DUT. A separate reference memory
// and load-result register are updated from the access rules (lane
// replacement, extension arithmetic) and compared against the DUT and the
// memory it actually wrote.
module tb_unidade_load_store;

   logic        clock;
   logic        reset;
   logic        req;
   logic        escrita;
   logic        byte_acc;
   logic        sel_byte;
   logic        com_sinal;
   logic [15:0] endereco_in;
   logic [15:0] dado_in;
   logic [15:0] dado_out;
   logic        ocupado;
   logic        pronto;
   logic        mem_hab_escrita;
   logic [15:0] mem_endereco;
   logic [15:0] mem_entrada;
   logic [15:0] mem_saida;

   logic [15:0] env_mem [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] ref_dado;

   int checks;
   int failures;

   unidade_load_store #(
      .bits_palavra (16),
      .end_registros(16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req            (req),
      .escrita        (escrita),
      .byte_acc       (byte_acc),
      .sel_byte       (sel_byte),
      .com_sinal      (com_sinal),
      .endereco_in    (endereco_in),
      .dado_in        (dado_in),
      .dado_out       (dado_out),
      .ocupado        (ocupado),
      .pronto         (pronto),
      .mem_hab_escrita(mem_hab_escrita),
      .mem_endereco   (mem_endereco),
      .mem_entrada    (mem_entrada),
      .mem_saida      (mem_saida)
   );

   // 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Data memory: the output registers the word at the sampled address
   // (old contents on a same-edge write), and writes land on the edge.
   always @(posedge clock) begin
      mem_saida <= env_mem[mem_endereco];
      if (mem_hab_escrita) begin
         env_mem[mem_endereco] = mem_entrada;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Runs one request starting at a negedge in an idle (or pronto) cycle and
   // returns at the negedge where pronto is seen, so the next call can issue
   // its request back to back. 'keep' leaves req high after acceptance.
   task automatic applyStimulus(input string tag, input bit esc, input bit byt,
                                input bit sel, input bit sin,
                                input logic [15:0] a, input logic [15:0] d,
                                input bit keep);
      int          lat_exp;
      int          lat_obs;
      int          wr_cnt;
      int          busy_gap;
      int          v;
      logic [15:0] novo;
      logic [15:0] addr_n1;
      logic [15:0] wr_a;
      logic [15:0] wr_d;
      logic [7:0]  b;

      lat_exp = esc ? (byt ? 4 : 2) : 3;
      novo    = ref_mem[a];
      if (esc) begin
         if (!byt) begin
            novo = d;
         end else if (sel) begin
            novo[15:8] = d[7:0];
         end else begin
            novo[7:0] = d[7:0];
         end
         ref_mem[a] = novo;
      end else if (!byt) begin
         ref_dado = novo;
      end else begin
         b = sel ? novo[15:8] : novo[7:0];
         v = int'(b);
         if (sin && v >= 128) v = v - 256;
         ref_dado = v[15:0];
      end

      req         = 1'b1;
      escrita     = esc;
      byte_acc    = byt;
      sel_byte    = sel;
      com_sinal   = sin;
      endereco_in = a;
      dado_in     = d;

      lat_obs  = 0;
      wr_cnt   = 0;
      busy_gap = 0;
      addr_n1  = '0;
      wr_a     = '0;
      wr_d     = '0;
      for (int i = 1; i <= 8 && lat_obs == 0; i++) begin
         @(negedge clock);
         if (i == 1) begin
            if (!keep) req = 1'b0;
            endereco_in = 16'($urandom);
            dado_in     = 16'($urandom);
            addr_n1     = mem_endereco;
         end
         if (mem_hab_escrita) begin
            wr_cnt++;
            wr_a = mem_endereco;
            wr_d = mem_entrada;
         end
         if (pronto) begin
            lat_obs = i;
         end else if (!ocupado) begin
            busy_gap++;
         end
      end

      checkOutput({tag, "_latency"}, lat_obs, lat_exp);
      checkOutput({tag, "_busy"}, busy_gap, 0);
      checkOutput({tag, "_addr_latched"}, addr_n1, a);
      checkOutput({tag, "_writes"}, wr_cnt, esc ? 1 : 0);
      if (esc) begin
         checkOutput({tag, "_wr_addr"}, wr_a, a);
         checkOutput({tag, "_wr_data"}, wr_d, novo);
      end
      checkOutput({tag, "_addr_held"}, mem_endereco, a);
      checkOutput({tag, "_dado_out"}, dado_out, ref_dado);
      checkOutput({tag, "_mem"}, env_mem[a], ref_mem[a]);
   endtask

   initial begin
      logic [15:0] addr;
      int          wr_seen;

      checks    = 0;
      failures  = 0;
      ref_dado  = '0;
      reset     = 1'b0;
      req       = 1'b0;
      escrita   = 1'b0;
      byte_acc  = 1'b0;
      sel_byte  = 1'b0;
      com_sinal = 1'b0;
      endereco_in = '0;
      dado_in     = '0;
      for (int i = 0; i < 65536; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < 8; i++) begin
         addr = 16'h0100 + 16'(i);
         env_mem[addr] = 16'($urandom);
         ref_mem[addr] = env_mem[addr];
      end

      // Reset state.
      repeat (3) @(negedge clock);
      checkOutput("rst_dado_out", dado_out, 16'h0);
      checkOutput("rst_ocupado", ocupado, 1'b0);
      checkOutput("rst_pronto", pronto, 1'b0);
      checkOutput("rst_we", mem_hab_escrita, 1'b0);
      checkOutput("rst_addr", mem_endereco, 16'h0);
      checkOutput("rst_wdata", mem_entrada, 16'h0);
      reset = 1'b1;
      @(negedge clock);

      // Word store then load.
      applyStimulus("wst", 1, 0, 0, 0, 16'h0010, 16'hBEEF, 0);
      applyStimulus("wld", 0, 0, 0, 0, 16'h0010, 16'h0000, 0);
      checkOutput("tp_word_load", dado_out, 16'hBEEF);

      // Byte store into the high lane.
      env_mem[16'h0020] = 16'h1234;
      ref_mem[16'h0020] = 16'h1234;
      applyStimulus("bst_hi", 1, 1, 1, 0, 16'h0020, 16'h00AB, 0);
      checkOutput("tp_byte_store", env_mem[16'h0020], 16'hAB34);

      // Byte load extension.
      env_mem[16'h0030] = 16'h80F0;
      ref_mem[16'h0030] = 16'h80F0;
      applyStimulus("bld_lo_s", 0, 1, 0, 1, 16'h0030, 16'h0000, 0);
      checkOutput("tp_sext", dado_out, 16'hFFF0);
      applyStimulus("bld_hi_z", 0, 1, 1, 0, 16'h0030, 16'h0000, 0);
      checkOutput("tp_zext", dado_out, 16'h0080);

      // Address extremes.
      applyStimulus("wst_max", 1, 0, 0, 0, 16'hFFFF, 16'hC0DE, 0);
      applyStimulus("bst_zero", 1, 1, 0, 0, 16'h0000, 16'h005A, 0);
      applyStimulus("wld_max", 0, 0, 0, 0, 16'hFFFF, 16'h0000, 0);
      applyStimulus("wld_zero", 0, 0, 0, 0, 16'h0000, 16'h0000, 0);

      // Back to back with req held; mid-operation address changes are ignored.
      applyStimulus("b2b_1", 1, 0, 0, 0, 16'h0050, 16'h1111, 1);
      applyStimulus("b2b_2", 1, 1, 1, 0, 16'h0050, 16'h0022, 1);
      applyStimulus("b2b_3", 0, 0, 0, 0, 16'h0050, 16'h0000, 1);
      applyStimulus("b2b_4", 0, 1, 1, 1, 16'h0050, 16'h0000, 0);

      // Reset in the middle of a byte store.
      env_mem[16'h0040] = 16'h5555;
      ref_mem[16'h0040] = 16'h5555;
      req         = 1'b1;
      escrita     = 1'b1;
      byte_acc    = 1'b1;
      sel_byte    = 1'b0;
      com_sinal   = 1'b0;
      endereco_in = 16'h0040;
      dado_in     = 16'h0077;
      @(negedge clock);
      req = 1'b0;
      @(negedge clock);
      checkOutput("abort_busy_before", ocupado, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("abort_dado_out", dado_out, 16'h0);
      checkOutput("abort_ocupado", ocupado, 1'b0);
      checkOutput("abort_pronto", pronto, 1'b0);
      checkOutput("abort_we", mem_hab_escrita, 1'b0);
      checkOutput("abort_addr", mem_endereco, 16'h0);
      checkOutput("abort_wdata", mem_entrada, 16'h0);
      ref_dado = '0;
      wr_seen  = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (mem_hab_escrita) wr_seen++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (mem_hab_escrita) wr_seen++;
      end
      checkOutput("abort_no_write", wr_seen, 0);
      applyStimulus("abort_reload", 0, 0, 0, 0, 16'h0040, 16'h0000, 0);
      checkOutput("tp_abort_mem", dado_out, 16'h5555);

      // Randomized operations over a small address pool plus the extremes.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       addr = 16'h0000;
            1:       addr = 16'hFFFF;
            default: addr = 16'h0100 + 16'($urandom_range(0, 7));
         endcase
         applyStimulus("rnd", 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), addr, 16'($urandom), 1'($urandom));
      end
      req = 1'b0;
      repeat (2) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

Load/store controller between the processor's memory-access stage and the data memory. Accepts one word or byte load/store request at a time. Drives the memory's write enable, address and write data, and returns load results. Byte stores use a read-modify-write sequence. The data memory has a registered read: its output updates on the clock edge that samples the address.

## Interface
Parameters:
- bits_palavra, 16, data word width; byte mode is defined for 16 only.
- end_registros, 16, word address width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in OCIOSO.
- escrita  in  1  1 = store, 0 = load.
- byte_acc  in  1  1 = byte access, 0 = word access.
- sel_byte  in  1  byte lane: 0 = bits [7:0], 1 = bits [15:8].
- com_sinal  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- endereco_in  in  end_registros  word address.
- dado_in  in  bits_palavra  store data; byte store uses dado_in[7:0].
- dado_out  out  bits_palavra  load result; registered.
- ocupado  out  1  high whenever state != OCIOSO.
- pronto  out  1  one-cycle completion pulse.
- mem_hab_escrita  out  1  memory write enable.
- mem_endereco  out  end_registros  memory address.
- mem_entrada  out  bits_palavra  memory write data.
- mem_saida  in  bits_palavra  memory read data; valid the cycle after the address is presented.

## Operation
- States:
  - OCIOSO: idle.
  - LE: address driven, read issued.
  - CAPTURA: mem_saida valid.
  - ESCREVE: write enable high.
- Accepting a request:
  - Accepted on the rising edge when state = OCIOSO and req = 1.
  - On that edge, latch endereco_in, dado_in, escrita, byte_acc, sel_byte and com_sinal.
  - req in any other state is ignored. There is no queue; the requester holds req until it sees pronto.
- Transitions from OCIOSO on an accepted request:
  - Word store → ESCREVE.
  - Load or byte store → LE.
- LE → CAPTURA unconditionally.
- CAPTURA:
  - Load → OCIOSO.
    - dado_out <= mem_saida for a word load.
    - For a byte load, select the lane, then zero- or sign-extend it to 16 bits.
  - Byte store → ESCREVE. Latch the merged word into the write-data register:
    - sel_byte = 0 → {mem_saida[15:8], dado[7:0]}.
    - sel_byte = 1 → {dado[7:0], mem_saida[7:0]}.
- ESCREVE:
  - mem_hab_escrita = 1 for exactly this cycle.
  - mem_entrada = word to write.
  - Next state → OCIOSO.
- Memory-side outputs:
  - mem_endereco = latched address, held after completion.
  - mem_hab_escrita = 0 in every state other than ESCREVE.
- pronto:
  - Registered; high for exactly one cycle, in the first OCIOSO cycle after completion.
  - A new request may be accepted in that same cycle, so back-to-back operation is allowed.
- dado_out changes only on load completion. Stores leave it unchanged.
- Reset (reset = 0, any time, mid-operation included):
  - State → OCIOSO.
  - dado_out, mem_endereco, mem_entrada, all latches = 0.
  - pronto = 0, mem_hab_escrita = 0.
  - No partial write is issued afterwards; an aborted byte store leaves memory untouched.

## Timing
- E0 is the accept edge.
- Word store:
  - ESCREVE during E0–E1; memory writes at E1.
  - pronto high E1–E2.
  - Latency 2 cycles from accept to pronto.
- Load (word or byte):
  - LE during E0–E1; memory registers data at E1.
  - CAPTURA during E1–E2; dado_out valid from E2.
  - pronto high E2–E3.
  - Latency 3 cycles.
- Byte store:
  - LE, then CAPTURA, then ESCREVE during E2–E3; write at E3.
  - pronto high E3–E4.
  - Latency 4 cycles.
- ocupado is high from E0 until the edge that sets pronto.
- Address-range edge cases: address 0 and address 2^end_registros−1 behave identically to any other address; there is no wrap or range check.

## Test plan
- Word store then load:
  - Store 0xBEEF @0x0010, then load @0x0010.
  - Expect mem_hab_escrita high exactly 1 cycle and pronto 2 cycles after accept.
  - Expect dado_out = 0xBEEF and pronto 3 cycles after the load accept.
- Byte store into high lane:
  - Memory @0x0020 = 0x1234; byte store dado_in = 0x00AB, sel_byte = 1.
  - Expect a read, then one write of 0xAB34; pronto at cycle 4.
- Byte load extension:
  - Memory @0x0030 = 0x80F0.
  - Lane 0, com_sinal = 1 → dado_out = 0xFFF0.
  - Lane 1, com_sinal = 0 → dado_out = 0x0080.
- Busy and back-to-back handling:
  - Hold req high across two requests; toggle endereco_in while ocupado.
  - Expect the mid-op value is ignored, the second request is accepted in the pronto cycle, and there are no idle gaps.
- Reset mid byte store:
  - Assert reset = 0 during CAPTURA of a byte store to @0x0040 = 0x5555.
  - Expect all outputs 0 immediately and no write strobe.
  - Expect @0x0040 still reads 0x5555 after reset is released.
